snax_alu_acc: RTL and testbench

- Downstream consumer of the SNAX ALU PE result stream (c/c_valid/c_ready).
- Either sums a programmed number of PE results into one value (accumulate mode) or forwards each result unchanged (pass-through mode).
- Drives the PE's acc_ready input and presents results on a registered valid/ready port toward the streamer/writer.
- Per-job control via start/busy/done from the CSR manager.

---
 rtl/snax_alu_pkg.sv | 16 +
 rtl/snax_alu_out_reg.sv | 41 ++++
 rtl/snax_alu_acc.sv | 140 ++++++++++++++
 tb/tb_snax_alu_acc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_alu_pkg.sv
// Shared types and constants for the SNAX ALU result accumulator.
package snax_alu_pkg;

    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefLenWidth  = 16;

    localparam logic AccModePass = 1'b0;
    localparam logic AccModeSum  = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

endpackage

// File: rtl/snax_alu_out_reg.sv
// Single-entry valid/ready output register; load and drain may happen in the same cycle.
module snax_alu_out_reg #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    logic [DataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/snax_alu_acc.sv
// Consumes the SNAX ALU PE result stream; sums a job's results or forwards each one.
//
// state   | meaning
// StIdle  | waiting for start, PE stalled
// StRun   | accepting len results from the PE
// StFlush | waiting for the final result to leave the output register
module snax_alu_acc
    import snax_alu_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned LenWidth  = DefLenWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] c_i,
    input  logic                 c_valid_i,
    output logic                 c_ready_o,
    output logic                 acc_ready_o,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  cfg_len_i,
    input  logic                 cfg_acc_en_i,
    output logic [DataWidth-1:0] out_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e               state_q, state_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [LenWidth-1:0]  cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic                 done_zero_q, done_zero_d;

    logic                 out_valid;
    logic                 out_load;
    logic [DataWidth-1:0] out_data;
    logic                 flush_done;
    logic                 c_ready;
    logic                 hs;
    logic                 last;
    logic [DataWidth-1:0] acc_sum;

    // Ready toward the PE is combinational from out_ready_i to keep full throughput.
    assign c_ready = (state_q == StRun) && (!out_valid || out_ready_i);
    assign hs      = c_valid_i && c_ready;
    assign last    = (cnt_q == len_q - LenWidth'(1));
    assign acc_sum = acc_q + c_i;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        done_zero_d = 1'b0;
        flush_done  = 1'b0;
        out_load    = 1'b0;
        out_data    = c_i;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_len_i != '0) begin
                        state_d = StRun;
                        len_d   = cfg_len_i;
                        mode_d  = cfg_acc_en_i;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (hs) begin
                    cnt_d = cnt_q + LenWidth'(1);
                    if (mode_q == AccModeSum) begin
                        if (last) begin
                            out_load = 1'b1;
                            out_data = acc_sum;
                            acc_d    = '0;
                        end else begin
                            acc_d = acc_sum;
                        end
                    end else begin
                        out_load = 1'b1;
                    end
                    if (last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!out_valid || out_ready_i) begin
                    flush_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= AccModePass;
            acc_q       <= '0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            done_zero_q <= done_zero_d;
        end
    end

    snax_alu_out_reg #(
        .DataWidth (DataWidth)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (out_load),
        .data_i  (out_data),
        .data_o  (out_o),
        .valid_o (out_valid),
        .ready_i (out_ready_i)
    );

    assign out_valid_o = out_valid;
    assign c_ready_o   = c_ready;
    assign acc_ready_o = c_ready;
    assign busy_o      = (state_q == StRun) || (state_q == StFlush);
    assign done_o      = done_zero_q || flush_done;

endmodule

// File: tb/tb_snax_alu_acc.sv
// Directed self-checking bench for snax_alu_acc.
module tb_snax_alu_acc;

    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] c;
    logic          c_valid;
    logic          c_ready;
    logic          acc_ready;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic          cfg_acc_en;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    snax_alu_acc #(.DataWidth(DW), .LenWidth(LW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .c_i          (c),
        .c_valid_i    (c_valid),
        .c_ready_o    (c_ready),
        .acc_ready_o  (acc_ready),
        .start_i      (start),
        .cfg_len_i    (cfg_len),
        .cfg_acc_en_i (cfg_acc_en),
        .out_o        (out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [LW-1:0] len, input logic mode);
        start = 1'b1; cfg_len = len; cfg_acc_en = mode;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; c = '0; c_valid = 1'b0; start = 1'b0;
        cfg_len = '0; cfg_acc_en = 1'b0; out_ready = 1'b1;
        #6;
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h exp 0", out); end
        checks++; if ({out_valid, c_ready, acc_ready, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 00000", {out_valid, c_ready, acc_ready, busy, done});
        end
        #6 rst_n = 1'b1;
        tick();
        #1;
        checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL idle_c_ready: got %b exp 0", c_ready); end
    endtask

    task automatic test_accumulate();
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        do_start(16'd4, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            c = DW'(i); c_valid = 1'b1;
            #1;
            checks++; if (c_ready !== 1'b1 || acc_ready !== 1'b1) begin
                errors++; $display("FAIL acc_ready_%0d: got %b%b exp 11", i, c_ready, acc_ready);
            end
            tick();
            if (i < 4) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_early_valid_%0d: got %b exp 0", i, out_valid); end
            end
        end
        c_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out !== 64'd10) begin
            errors++; $display("FAIL acc_result: got v=%b %h exp v=1 %h", out_valid, out, 64'd10);
        end
        #1;
        checks++; if (c_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL acc_flush: got c_ready=%b done=%b busy=%b exp 0 1 1", c_ready, done, busy);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || c_ready !== 1'b0) begin
            errors++; $display("FAIL acc_idle: got v=%b busy=%b done=%b c_ready=%b exp 0000", out_valid, busy, done, c_ready);
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL acc_done_count: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_pass();
        logic [DW-1:0] vals [3];
        vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
        out_ready = 1'b1;
        do_start(16'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            c = vals[i]; c_valid = 1'b1;
            #1;
            checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL pass_ready_%0d: got %b exp 1", i, c_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out !== vals[i]) begin
                errors++; $display("FAIL pass_out_%0d: got v=%b %h exp v=1 %h", i, out_valid, out, vals[i]);
            end
        end
        c_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done: got %b exp 1", done); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL pass_idle: got v=%b busy=%b exp 00", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_start(16'd3, 1'b0);
        c = 64'h11; c_valid = 1'b1;
        #1;
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b exp 1", c_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out !== 64'h11) begin
            errors++; $display("FAIL bp_first_out: got v=%b %h exp v=1 11", out_valid, out);
        end
        c = 64'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (c_ready !== 1'b0 || acc_ready !== 1'b0 || out_valid !== 1'b1 || out !== 64'h11 || done !== 1'b0) begin
                errors++; $display("FAIL bp_stall_%0d: got c_ready=%b acc_ready=%b v=%b out=%h done=%b exp 0 0 1 11 0",
                                   i, c_ready, acc_ready, out_valid, out, done);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %b exp 1", c_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out !== 64'h22) begin
            errors++; $display("FAIL bp_second_out: got v=%b %h exp v=1 22", out_valid, out);
        end
        c = 64'h33;
        tick();
        checks++; if (out_valid !== 1'b1 || out !== 64'h33) begin
            errors++; $display("FAIL bp_third_out: got v=%b %h exp v=1 33", out_valid, out);
        end
        c_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", done); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle: got busy=%b v=%b exp 00", busy, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        do_start(16'd2, 1'b1);
        c = 64'hFFFF_FFFF_FFFF_FFFF; c_valid = 1'b1;
        tick();
        c = 64'd2;
        tick();
        c_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out !== 64'd1) begin
            errors++; $display("FAIL wrap_result: got v=%b %h exp v=1 1", out_valid, out);
        end
        tick();
    endtask

    task automatic test_len_zero();
        int d0;
        d0 = done_cnt;
        do_start(16'd0, 1'b1);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL len0_pulse: got done=%b busy=%b v=%b exp 1 0 0", done, busy, out_valid);
        end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL len0_after: got done=%b busy=%b v=%b exp 0 0 0", done, busy, out_valid);
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL len0_done_count: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_start_while_busy();
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        do_start(16'd2, 1'b1);
        c = 64'd3; c_valid = 1'b1;
        start = 1'b1; cfg_len = 16'd5; cfg_acc_en = 1'b0;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL busy_start_mid: got busy=%b v=%b exp 1 0", busy, out_valid);
        end
        c = 64'd4;
        tick();
        c_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out !== 64'd7) begin
            errors++; $display("FAIL busy_start_result: got v=%b %h exp v=1 7", out_valid, out);
        end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL busy_start_jobs: got busy=%b v=%b dones=%0d exp 0 0 1", busy, out_valid, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        do_start(16'd4, 1'b1);
        c = 64'd9; c_valid = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b exp 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, c_ready, acc_ready, busy, done} !== 5'b0 || out !== '0) begin
            errors++; $display("FAIL rst_mid: got ctrl=%b out=%h exp 00000 0", {out_valid, c_ready, acc_ready, busy, done}, out);
        end
        rst_n = 1'b1;
        c_valid = 1'b0;
        tick();
        do_start(16'd2, 1'b1);
        c = 64'd5; c_valid = 1'b1;
        tick();
        c = 64'd6;
        tick();
        c_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out !== 64'd11) begin
            errors++; $display("FAIL rst_new_job: got v=%b %h exp v=1 b", out_valid, out);
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_new_idle: got busy=%b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_pass();
        test_backpressure();
        test_wrap();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
